// File: rtl/vcxo_lock_monitor.sv
// Lock qualifier for the VCXO/TCXO discipline loop: hysteretic lock, stall detect, PWM rail alarm, peak error.
// Optional lock_history shift register enabled by defining VCXO_LOCK_HISTORY_EN.
`timescale 1ns/1ps
module vcxo_lock_monitor #(
    parameter int LOCK_THRESH    = 8,
    parameter int LOCK_COUNT     = 4,
    parameter int UNLOCK_COUNT   = 3,
    parameter int TIMEOUT_CYCLES = 25000000,
    parameter int PWM_MAX        = 122880
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic signed [23:0] freq_error,
    input  logic               freq_error_valid,
    input  logic signed [23:0] PWM,
    input  logic               peak_clear,
    output logic               locked,
    output logic               lock_lost,
    output logic               stalled,
    output logic               rail_alarm,
    output logic [23:0]        peak_error,
    output logic [1:0]         state_out
`ifdef VCXO_LOCK_HISTORY_EN
    ,
    output logic [15:0]        lock_history
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    localparam logic [TW-1:0]        TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]        GOOD_TARGET  = GW'(LOCK_COUNT);
    localparam logic [BW-1:0]        BAD_TARGET   = BW'(UNLOCK_COUNT);
    localparam logic [23:0]          THRESH       = 24'(LOCK_THRESH);
    localparam logic signed [23:0]   PWM_MAX_S    = 24'(PWM_MAX);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_STALLED  = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    state_t         state_reg;
    logic [TW-1:0]  timer_reg;
    logic [GW-1:0]  good_cnt_reg;
    logic [BW-1:0]  bad_cnt_reg;
    logic           locked_reg;
    logic           lock_lost_reg;
    logic           stalled_reg;
    logic           rail_alarm_reg;
    logic [23:0]    peak_error_reg;

    logic [23:0]    abs_err;
    logic           sample_good;
    logic           rail_cond;
    logic           stall_hit;
    logic [GW-1:0]  good_cnt_inc;
    logic [BW-1:0]  bad_cnt_inc;

    // The most negative code has no positive twin, so it clamps to full scale.
    always_comb begin
        abs_err = freq_error;
        if (freq_error == 24'sh800000)
            abs_err = 24'h7FFFFF;
        else if (freq_error[23])
            abs_err = $unsigned(-freq_error);
    end

    assign sample_good  = (abs_err <= THRESH);
    assign rail_cond    = (PWM <= 24'sd0) || (PWM >= PWM_MAX_S);
    // A strobe on the expiry cycle resets the timer, so it suppresses the stall.
    assign stall_hit    = !freq_error_valid && (timer_reg >= TIMEOUT_LAST);
    assign good_cnt_inc = (good_cnt_reg == GOOD_TARGET) ? good_cnt_reg : good_cnt_reg + 1'b1;
    assign bad_cnt_inc  = (bad_cnt_reg == BAD_TARGET) ? bad_cnt_reg : bad_cnt_reg + 1'b1;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_UNLOCKED;
            timer_reg      <= '0;
            good_cnt_reg   <= '0;
            bad_cnt_reg    <= '0;
            locked_reg     <= 1'b0;
            lock_lost_reg  <= 1'b0;
            stalled_reg    <= 1'b0;
            rail_alarm_reg <= 1'b0;
            peak_error_reg <= '0;
        end else begin
            lock_lost_reg <= 1'b0;

            if (freq_error_valid)
                timer_reg <= '0;
            else if (timer_reg != TIMEOUT_MAX)
                timer_reg <= timer_reg + 1'b1;

            case (state_reg)
                // good_cnt is already zero in STALLED, so the returning sample counts as the first one.
                ST_UNLOCKED, ST_STALLED: begin
                    if (freq_error_valid) begin
                        stalled_reg <= 1'b0;
                        if (sample_good && good_cnt_inc == GOOD_TARGET) begin
                            state_reg    <= ST_LOCKED;
                            locked_reg   <= 1'b1;
                            good_cnt_reg <= '0;
                        end else begin
                            state_reg    <= ST_UNLOCKED;
                            good_cnt_reg <= sample_good ? good_cnt_inc : '0;
                        end
                    end else if (stall_hit && state_reg == ST_UNLOCKED) begin
                        state_reg    <= ST_STALLED;
                        stalled_reg  <= 1'b1;
                        good_cnt_reg <= '0;
                        bad_cnt_reg  <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (freq_error_valid) begin
                        if (sample_good) begin
                            bad_cnt_reg <= '0;
                        end else if (bad_cnt_inc == BAD_TARGET) begin
                            state_reg     <= ST_UNLOCKED;
                            locked_reg    <= 1'b0;
                            lock_lost_reg <= 1'b1;
                            bad_cnt_reg   <= '0;
                        end else begin
                            bad_cnt_reg <= bad_cnt_inc;
                        end
                    end else if (stall_hit) begin
                        state_reg     <= ST_STALLED;
                        stalled_reg   <= 1'b1;
                        locked_reg    <= 1'b0;
                        lock_lost_reg <= 1'b1;
                        good_cnt_reg  <= '0;
                        bad_cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg    <= ST_UNLOCKED;
                    locked_reg   <= 1'b0;
                    stalled_reg  <= 1'b0;
                    good_cnt_reg <= '0;
                    bad_cnt_reg  <= '0;
                end
            endcase

            if (peak_clear)
                rail_alarm_reg <= rail_cond;
            else if (rail_cond)
                rail_alarm_reg <= 1'b1;

            if (peak_clear)
                peak_error_reg <= freq_error_valid ? abs_err : '0;
            else if (freq_error_valid && abs_err > peak_error_reg)
                peak_error_reg <= abs_err;
        end
    end

    assign locked     = locked_reg;
    assign lock_lost  = lock_lost_reg;
    assign stalled    = stalled_reg;
    assign rail_alarm = rail_alarm_reg;
    assign peak_error = peak_error_reg;
    assign state_out  = state_reg;

`ifdef VCXO_LOCK_HISTORY_EN
    logic [15:0] history_reg;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)
            history_reg <= '0;
        else if (freq_error_valid)
            history_reg <= {history_reg[14:0], sample_good};
    end

    assign lock_history = history_reg;
`endif

endmodule

// File: doc/vcxo_lock_monitor.md
Name: vcxo_lock_monitor

Overview:
- Sits directly downstream of the VCXO/TCXO frequency-discipline loop.
- Consumes each per-window frequency-error sample and the loop's PWM duty value.
- Qualifies lock with hysteresis, flags a stalled loop (no samples arriving), flags PWM saturation at either rail, and keeps a peak-error register.
- Status goes to the MCU register interface and gates the front-panel "REF LOCK" indication.

Parameters:
- LOCK_THRESH, 8, max |freq_error| (x100 Hz units) for a sample to count as good
- LOCK_COUNT, 4, consecutive good samples needed to declare lock
- UNLOCK_COUNT, 3, consecutive bad samples needed to drop lock
- TIMEOUT_CYCLES, 25000000, clk_in cycles without freq_error_valid before declaring the loop stalled
- PWM_MAX, 122880, PWM full-scale value; PWM >= PWM_MAX counts as upper rail

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- freq_error  input  24 signed  latest measured frequency error
- freq_error_valid  input  1  one-cycle strobe; freq_error is valid this cycle
- PWM  input  24 signed  current loop PWM duty value
- peak_clear  input  1  one-cycle strobe; clears peak_error and rail_alarm
- locked  output  1  registered lock status
- lock_lost  output  1  one-cycle pulse on the LOCKED->UNLOCKED transition
- stalled  output  1  high while in STALLED state
- rail_alarm  output  1  sticky; PWM reached 0 or PWM_MAX
- peak_error  output  24  unsigned peak |freq_error| since last clear
- state_out  output  2  encoded FSM state

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM = UNLOCKED (state_out 0), all counters 0.
- Magnitude: abs_err = |freq_error|. A value of -2^23 saturates to 2^23-1. Sample is good iff abs_err <= LOCK_THRESH.
- FSM encoding: UNLOCKED=0, LOCKED=1, STALLED=2; 3 is unused and returns to UNLOCKED on the next clock.
- UNLOCKED:
  - Each valid good sample increments good_cnt.
  - A valid bad sample clears good_cnt.
  - On the sample where good_cnt reaches LOCK_COUNT: go to LOCKED, clear good_cnt. locked rises on the clock edge after that strobe (1-cycle latency).
- LOCKED:
  - A valid bad sample increments bad_cnt; a valid good sample clears bad_cnt.
  - When bad_cnt reaches UNLOCK_COUNT: go to UNLOCKED, locked <= 0, lock_lost pulses for exactly one cycle, bad_cnt cleared.
- Stall timer (all states):
  - Counts clk_in cycles since the last freq_error_valid and saturates at TIMEOUT_CYCLES.
  - Reset to 0 on every valid strobe.
  - When it reaches TIMEOUT_CYCLES in UNLOCKED or LOCKED: go to STALLED, clear locked, clear good_cnt and bad_cnt.
  - Leaving LOCKED for STALLED also pulses lock_lost.
- STALLED: the next valid strobe returns to UNLOCKED, and that sample is evaluated as the first UNLOCKED sample (good_cnt may become 1).
- Stall vs sample: if a valid strobe arrives on the same cycle the timer would expire, the strobe wins and there is no stall.
- Rail alarm: sampled every cycle, not only on strobes. PWM <= 0 or PWM >= PWM_MAX sets rail_alarm; it holds until peak_clear.
- Peak error: on each valid strobe, peak_error <= max(peak_error, abs_err).
- peak_clear with a simultaneous valid strobe: peak_error <= abs_err of the new sample. rail_alarm clears unless the rail condition is true that same cycle, in which case it stays 1.
- Counters saturate and never wrap.
- freq_error_valid held high for multiple cycles counts one sample per cycle (by design; upstream guarantees single-cycle strobes).

Optional Feature:
- Macro: VCXO_LOCK_HISTORY_EN
- Defined:
  - Adds output lock_history [15:0].
  - On each valid strobe, shifts left and inserts the good/bad bit (1 = good) at bit 0.
  - Reset value 0; not affected by peak_clear; holds during STALLED.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Acquire: reset, then strobes with freq_error = 3, -5, 8, 0 -> locked=1 one cycle after the 4th strobe; state_out=1; peak_error=8.
- Lose lock: from LOCKED, strobes 20, 2, 20, 20, 20 -> still locked after the 2 interrupts the run; lock_lost single pulse and locked=0 after the 5th strobe; peak_error=20.
- Stall: TIMEOUT_CYCLES=100, no strobes for 100 cycles while LOCKED -> stalled=1, locked=0, lock_lost pulse. Next strobe with freq_error=1 -> state_out=0, stalled=0.
- Saturation: freq_error = 0x800000 strobe -> peak_error = 0x7FFFFF, sample is bad. PWM = 0 for one cycle -> rail_alarm=1 and stays 1 until peak_clear.
- Simultaneous: peak_clear and strobe with freq_error=-6 in the same cycle -> peak_error=6. Strobe on the exact timeout cycle -> no stall.
- With VCXO_LOCK_HISTORY_EN: strobes 1, 50, 1 -> lock_history = 16'h0005.
